// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller: USER/KERNEL/FAULT mode FSM that redirects the PC on exceptions, interrupts and eret.
// Define IRQ_EDGE_DETECT_EN for latched rising-edge interrupt capture; default build is level-sensitive.
module exc_irq_ctrl #(
   parameter int unsigned         NUM_IRQ    = 4,
   parameter int unsigned         PC_WIDTH   = 32,
   parameter logic [PC_WIDTH-1:0] IRQ_VECTOR = PC_WIDTH'(32'h80000004),
   parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(32'h80000008)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_IRQ-1:0]  irq_in,
   input  logic [NUM_IRQ-1:0]  irq_mask,
   input  logic                undef_inst,
   input  logic                eret,
   input  logic                id_valid,
   input  logic                stall,
   input  logic [PC_WIDTH-1:0] id_pc,
   output logic                take,
   output logic [2:0]          pc_src,
   output logic [PC_WIDTH-1:0] vector,
   output logic                flush_if_id,
   output logic [PC_WIDTH-1:0] epc,
   output logic [3:0]          irq_cause,
   output logic                kernel_mode,
   output logic                fault
);

   typedef enum logic [1:0] {USER, KERNEL, FAULT} state_t;

   state_t state, state_nxt;

   logic               ev;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] elig;
   logic [NUM_IRQ-1:0] win_oh;
   logic [3:0]         win_idx;
   logic               any_irq;
   logic               exc_user;
   logic               take_irq;
   logic               take_ret;
   logic               to_fault;

   assign ev      = id_valid & ~stall;
   assign elig    = pend & irq_mask;
   assign any_irq = |elig;

   // Lowest eligible channel wins.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (elig[i] && (win_oh == '0)) begin
            win_oh[i] = 1'b1;
            win_idx   = 4'(i);
         end
      end
   end

   // eret in USER is treated as an undefined instruction.
   assign exc_user = ev && (state == USER) && (undef_inst || eret);
   assign take_irq = ev && (state == USER) && !(undef_inst || eret) && any_irq;
   assign take_ret = ev && (state == KERNEL) && eret && !undef_inst;
   assign to_fault = ev && (state == KERNEL) && undef_inst;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= USER;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         USER:    if (exc_user || take_irq) state_nxt = KERNEL;
         KERNEL:  begin
            if (to_fault)      state_nxt = FAULT;
            else if (take_ret) state_nxt = USER;
         end
         FAULT:   state_nxt = FAULT;
         default: state_nxt = FAULT;
      endcase
   end

   // Redirect outputs are combinational; reset forces them quiet to cancel any in-flight redirect.
   always_comb begin
      take        = 1'b0;
      pc_src      = 3'b000;
      vector      = '0;
      flush_if_id = 1'b0;
      if (!reset) begin
         if (exc_user) begin
            take        = 1'b1;
            pc_src      = 3'b101;
            vector      = EXC_VECTOR;
            flush_if_id = 1'b1;
         end else if (take_irq) begin
            take        = 1'b1;
            pc_src      = 3'b100;
            vector      = IRQ_VECTOR;
            flush_if_id = 1'b1;
         end else if (take_ret) begin
            take        = 1'b1;
            pc_src      = 3'b110;
            vector      = epc;
            flush_if_id = 1'b1;
         end
      end
   end

   assign kernel_mode = (state != USER) && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         epc       <= '0;
         irq_cause <= '0;
         fault     <= 1'b0;
      end else begin
         if (exc_user || take_irq) epc <= id_pc;
         if (take_irq)             irq_cause <= win_idx;
         if (to_fault)             fault <= 1'b1;
      end
   end

`ifdef IRQ_EDGE_DETECT_EN
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] clr;

   assign clr = take_irq ? win_oh : '0;

   // A fresh rising edge overrides the clear, so a request re-asserted on the take edge is kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_prev <= '0;
         pend     <= '0;
      end else begin
         irq_prev <= irq_in;
         pend     <= (pend & ~clr) | (irq_in & ~irq_prev);
      end
   end
`else
   assign pend = irq_in;
`endif

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Self-checking bench for exc_irq_ctrl: directed scenarios plus random traffic against a rule-level reference model.
module tb_exc_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq_in, irq_mask;
   logic        undef_inst, eret, id_valid, stall;
   logic [31:0] id_pc;
   logic        take, flush_if_id, kernel_mode, fault;
   logic [2:0]  pc_src;
   logic [31:0] vector, epc;
   logic [3:0]  irq_cause;

   int checks = 0;
   int errors = 0;

   exc_irq_ctrl #(.NUM_IRQ(4), .PC_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .irq_mask(irq_mask),
      .undef_inst(undef_inst), .eret(eret), .id_valid(id_valid), .stall(stall),
      .id_pc(id_pc), .take(take), .pc_src(pc_src), .vector(vector),
      .flush_if_id(flush_if_id), .epc(epc), .irq_cause(irq_cause),
      .kernel_mode(kernel_mode), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef enum {M_USER, M_KERNEL, M_FAULT} mode_t;
   typedef struct {
      logic        take;
      logic [2:0]  src;
      logic [31:0] vec;
      mode_t       nmode;
      logic        save_epc;
      logic        save_cause;
      logic [3:0]  cause;
      logic [3:0]  clr;
      logic        set_fault;
   } dec_t;

   mode_t       m_mode;
   logic [31:0] m_epc;
   logic [3:0]  m_cause;
   logic        m_fault;
   logic [3:0]  m_pend;
   logic [3:0]  m_prev;

   function automatic logic [3:0] lowest_idx(logic [3:0] v);
      logic [3:0] iso;
      iso = v & (~v + 4'd1);
      return 4'($clog2(iso));
   endfunction

   // Behavioural rules: what happens this cycle given the architectural mode and inputs.
   function automatic dec_t decide();
      dec_t d;
      logic [3:0] pend_eff, elig;
      logic ev;
`ifdef IRQ_EDGE_DETECT_EN
      pend_eff = m_pend;
`else
      pend_eff = irq_in;
`endif
      elig = pend_eff & irq_mask;
      ev = id_valid && !stall;
      d = '{take: 1'b0, src: 3'd0, vec: 32'd0, nmode: m_mode, save_epc: 1'b0,
            save_cause: 1'b0, cause: 4'd0, clr: 4'd0, set_fault: 1'b0};
      if (reset || !ev) return d;
      if (m_mode == M_USER) begin
         if (undef_inst || eret) begin
            d.take = 1'b1; d.src = 3'b101; d.vec = 32'h80000008;
            d.nmode = M_KERNEL; d.save_epc = 1'b1;
         end else if (elig != 0) begin
            d.take = 1'b1; d.src = 3'b100; d.vec = 32'h80000004;
            d.nmode = M_KERNEL; d.save_epc = 1'b1; d.save_cause = 1'b1;
            d.cause = lowest_idx(elig);
            d.clr = 4'd1 << d.cause;
         end
      end else if (m_mode == M_KERNEL) begin
         if (undef_inst) begin
            d.nmode = M_FAULT; d.set_fault = 1'b1;
         end else if (eret) begin
            d.take = 1'b1; d.src = 3'b110; d.vec = m_epc; d.nmode = M_USER;
         end
      end
      return d;
   endfunction

   always @(posedge clk or posedge reset) begin
      dec_t d;
      if (reset) begin
         m_mode <= M_USER; m_epc <= 0; m_cause <= 0; m_fault <= 0; m_pend <= 0; m_prev <= 0;
      end else begin
         d = decide();
         m_mode <= d.nmode;
         if (d.save_epc)   m_epc <= id_pc;
         if (d.save_cause) m_cause <= d.cause;
         if (d.set_fault)  m_fault <= 1'b1;
         m_pend <= (m_pend & ~d.clr) | (irq_in & ~m_prev);
         m_prev <= irq_in;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      dec_t d;
      d = decide();
      check({tag, ".take"},   32'(take),        32'(d.take));
      check({tag, ".pc_src"}, 32'(pc_src),      32'(d.src));
      check({tag, ".vector"}, vector,           d.vec);
      check({tag, ".flush"},  32'(flush_if_id), 32'(d.take));
      check({tag, ".epc"},    epc,              m_epc);
      check({tag, ".cause"},  32'(irq_cause),   32'(m_cause));
      check({tag, ".kmode"},  32'(kernel_mode), 32'(m_mode != M_USER && !reset));
      check({tag, ".fault"},  32'(fault),       32'(m_fault));
   endtask

   task automatic drive(input string tag, input logic [3:0] irq, input logic [3:0] mask,
                        input logic und, input logic er, input logic vld, input logic stl,
                        input logic [31:0] pc);
      @(negedge clk);
      irq_in = irq; irq_mask = mask; undef_inst = und; eret = er;
      id_valid = vld; stall = stl; id_pc = pc;
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      irq_in = 0; irq_mask = 0; undef_inst = 0; eret = 0; id_valid = 0; stall = 0; id_pc = 0;
      #1;
      check_all("por");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Interrupt entry, lowest eligible channel of 0110 is 1.
      drive("irq", 4'b0110, 4'hF, 0, 0, 1, 0, 32'h100);
      check("irq.take_c", 32'(take), 32'd1);
      check("irq.vec_c",  vector, 32'h80000004);
      drive("irq_after", 4'b0000, 4'hF, 0, 0, 0, 0, 32'h104);
      check("irq.cause_c", 32'(irq_cause), 32'd1);
      check("irq.epc_c",   epc, 32'h100);
      check("irq.kmode_c", 32'(kernel_mode), 32'd1);

      // Return from exception.
      drive("eret", 4'b0000, 4'hF, 0, 1, 1, 0, 32'h104);
      check("eret.src_c", 32'(pc_src), 32'b110);
      check("eret.vec_c", vector, 32'h100);
      drive("eret_after", 4'b0000, 4'hF, 0, 0, 0, 0, 32'h0);
      check("eret.kmode_c", 32'(kernel_mode), 32'd0);

      // Exception beats a pending interrupt.
      drive("exc", 4'b0010, 4'hF, 1, 0, 1, 0, 32'h200);
      check("exc.src_c", 32'(pc_src), 32'b101);
      check("exc.vec_c", vector, 32'h80000008);
      drive("exc_after", 4'b0010, 4'hF, 0, 0, 0, 0, 32'h204);
      check("exc.epc_c",   epc, 32'h200);
      check("exc.cause_c", 32'(irq_cause), 32'd1);
      drive("exc_ret", 4'b0000, 4'hF, 0, 1, 1, 0, 32'h204);

      // Stall holds off a pending interrupt.
      for (int k = 0; k < 3; k++) begin
         drive("stall", 4'b1000, 4'hF, 0, 0, 1, 1, 32'h300);
         check("stall.take_c", 32'(take), 32'd0);
      end
      drive("unstall", 4'b1000, 4'hF, 0, 0, 1, 0, 32'h300);
      check("unstall.take_c", 32'(take), 32'd1);

      // Undefined instruction in KERNEL: double fault, sticky.
      drive("dfault", 4'b0000, 4'hF, 1, 0, 1, 0, 32'h304);
      for (int k = 0; k < 3; k++) begin
         drive("fault_hold", 4'b0001, 4'hF, 0, 1, 1, 0, 32'h308);
         check("fault.held_c", 32'(fault), 32'd1);
      end
      do_reset();

      // Asynchronous reset in KERNEL cancels a live eret redirect.
      drive("pre_k", 4'b0100, 4'hF, 0, 0, 1, 0, 32'h400);
      drive("k_eret", 4'b0000, 4'hF, 0, 1, 1, 0, 32'h404);
      #2;
      reset = 1'b1;
      #1;
      check("async.take",  32'(take), 32'd0);
      check("async.src",   32'(pc_src), 32'd0);
      check("async.kmode", 32'(kernel_mode), 32'd0);
      check("async.epc",   epc, 32'd0);
      check("async.cause", 32'(irq_cause), 32'd0);
      check_all("async");
      @(negedge clk);
      reset = 1'b0;

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         if (m_mode == M_FAULT && $urandom_range(0, 3) == 0) do_reset();
         drive("rand", 4'($urandom), 4'($urandom),
               $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
               $urandom & 32'hFFFF_FFFC);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
